// File: rtl/mvm_param_stream.sv
// Signed KxK matrix-vector multiplier: serial load of M and x over one bus, P-lane MAC compute,
// and a K-word result stream with valid/ready backpressure, optional saturation and a sticky overflow flag.
module mvm_param_stream #(
    parameter int K     = 32,
    parameter int B     = 8,
    parameter int P     = 4,
    parameter int OUT_W = 16,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_matrix,
    input  logic                    load_vector,
    input  logic                    start,
    input  logic signed [B-1:0]     data_in,
    input  logic                    data_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    out_last,
    output logic                    overflow
);

    localparam int ACC_W = 2 * B + $clog2(K);
    localparam int PW    = 2 * B;
    localparam int NG    = K / P;
    localparam int CW    = (K > 1) ? $clog2(K) : 1;
    localparam int GW    = (NG > 1) ? $clog2(NG) : 1;
    localparam int MAW   = (K * K > 1) ? $clog2(K * K) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_V,
        S_COMPUTE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [MAW-1:0] cnt_q;
    logic [CW-1:0]  col_q;
    logic [GW-1:0]  grp_q;
    logic           drn_q;
    logic [CW-1:0]  idx_q;
    logic           done_q;
    logic           ovf_q;

    logic signed [B-1:0]     m_mem [K*K];
    logic signed [B-1:0]     x_mem [K];
    logic signed [OUT_W-1:0] y_mem [K];

    logic                    vld_p0, first_p0, last_p0;
    logic [GW-1:0]           grp_p0;
    logic signed [PW-1:0]    prod_p0 [P];
    logic signed [ACC_W-1:0] acc_p1 [P];
    logic                    wr_p1;
    logic [GW-1:0]           grp_p1;

    logic [MAW-1:0]          m_addr [P];
    logic [CW-1:0]           y_addr [P];
    logic signed [OUT_W-1:0] y_sat  [P];
    logic [P-1:0]            lane_ovf;

    logic col_last, grp_last, cmd_start;

    // Returns {overflow, value}: value either clamps to the signed OUT_W range or keeps the low bits.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] a);
        logic signed [OUT_W-1:0] t;
        t = a[OUT_W-1:0];
        if (ACC_W'(t) == a)
            return {1'b0, t};
        else if (SAT != 0)
            return {1'b1, a[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}}};
        else
            return {1'b1, t};
    endfunction

    assign col_last  = (col_q == CW'(K - 1));
    assign grp_last  = (grp_q == GW'(NG - 1));
    assign cmd_start = (state_q == S_IDLE) && start && !load_matrix && !load_vector;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_matrix)      state_d = S_LOAD_M;
                else if (load_vector) state_d = S_LOAD_V;
                else if (start)       state_d = S_COMPUTE;
            end
            S_LOAD_M:  if (data_valid && cnt_q == MAW'(K * K - 1)) state_d = S_IDLE;
            S_LOAD_V:  if (data_valid && cnt_q == MAW'(K - 1))     state_d = S_IDLE;
            S_COMPUTE: if (col_last && grp_last)                   state_d = S_DRAIN;
            S_DRAIN:   if (drn_q)                                  state_d = S_OUT;
            S_OUT:     if (out_ready && idx_q == CW'(K - 1))       state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            m_addr[p] = MAW'((int'(grp_q) * P + p) * K + int'(col_q));
            y_addr[p] = CW'(int'(grp_p1) * P + p);
            {lane_ovf[p], y_sat[p]} = sat_fn(acc_p1[p]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            col_q    <= '0;
            grp_q    <= '0;
            drn_q    <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            grp_p0   <= '0;
            wr_p1    <= 1'b0;
            grp_p1   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_DRAIN) && drn_q;

            if (cmd_start)
                ovf_q <= 1'b0;
            else if (wr_p1 && |lane_ovf)
                ovf_q <= 1'b1;

            // p0: product issue flags
            vld_p0   <= (state_q == S_COMPUTE);
            first_p0 <= (col_q == '0);
            last_p0  <= col_last;
            grp_p0   <= grp_q;

            // p1: accumulator holds a finished row sum when the last column was accumulated
            wr_p1  <= vld_p0 && last_p0;
            grp_p1 <= grp_p0;

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    col_q <= '0;
                    grp_q <= '0;
                    drn_q <= 1'b0;
                    idx_q <= '0;
                end
                S_LOAD_M, S_LOAD_V: if (data_valid) cnt_q <= cnt_q + MAW'(1);
                S_COMPUTE: begin
                    col_q <= col_last ? '0 : col_q + CW'(1);
                    if (col_last) grp_q <= grp_q + GW'(1);
                end
                S_DRAIN: drn_q <= 1'b1;
                S_OUT:   if (out_ready) idx_q <= idx_q + CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_M && data_valid) m_mem[cnt_q] <= data_in;
        if (state_q == S_LOAD_V && data_valid) x_mem[cnt_q[CW-1:0]] <= data_in;

        for (int p = 0; p < P; p++) begin
            // p0: one product per lane per cycle
            if (state_q == S_COMPUTE)
                prod_p0[p] <= PW'(m_mem[m_addr[p]]) * PW'(x_mem[col_q]);
            // p1: accumulate, restarting on column 0
            if (vld_p0)
                acc_p1[p] <= first_p0 ? ACC_W'(prod_p0[p]) : acc_p1[p] + ACC_W'(prod_p0[p]);
            // result buffer write after width reduction
            if (wr_p1)
                y_mem[y_addr[p]] <= y_sat[p];
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign data_out  = out_valid ? y_mem[idx_q] : '0;
    assign out_last  = out_valid && (idx_q == CW'(K - 1));

endmodule

// File: tb/tb_mvm_param_stream.sv
// Bench for mvm_param_stream: directed load/compute/stream scenarios with random data,
// checked against a plain-arithmetic matrix-vector reference model.
module tb_mvm_param_stream;

    localparam int K     = 32;
    localparam int B     = 8;
    localparam int P     = 4;
    localparam int OUT_W = 16;
    localparam int SAT   = 1;
    localparam int LAT   = K * K / P + 2;
    localparam longint MAXV = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OUT_W - 1));

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    load_matrix, load_vector, start;
    logic signed [B-1:0]     data_in;
    logic                    data_valid;
    logic                    busy, done, out_valid, out_ready, out_last, overflow;
    logic signed [OUT_W-1:0] data_out;

    int mm [K][K];
    int xv [K];
    int yexp [K];
    bit oexp;
    int n_chk = 0;
    int n_fail = 0;

    mvm_param_stream #(.K(K), .B(B), .P(P), .OUT_W(OUT_W), .SAT(SAT)) dut (
        .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
        .start(start), .data_in(data_in), .data_valid(data_valid), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        oexp = 1'b0;
        for (int i = 0; i < K; i++) begin
            longint s = 0;
            for (int c = 0; c < K; c++) s += longint'(mm[i][c]) * longint'(xv[c]);
            if (s > MAXV)      begin yexp[i] = int'(MAXV); oexp = 1'b1; end
            else if (s < MINV) begin yexp[i] = int'(MINV); oexp = 1'b1; end
            else               yexp[i] = int'(s);
        end
    endtask

    // mode: 0 dense, 1 alternate valid/gap, 2 random gaps
    task automatic load(input bit vec, input int mode, input bit also_start);
        int  total = vec ? K : K * K;
        int  i = 0;
        int  tog = 0;
        bit  busy_ok = 1'b1;
        bit  gap;
        @(negedge clk);
        if (vec) begin load_vector = 1'b1; start = also_start; end
        else load_matrix = 1'b1;
        @(negedge clk);
        load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0;
        while (i < total) begin
            case (mode)
                0:       gap = 1'b0;
                1:       gap = tog[0];
                default: gap = ($urandom_range(2) == 0);
            endcase
            tog++;
            if (gap) begin
                data_valid = 1'b0;
                data_in = B'($urandom);
            end else begin
                data_valid = 1'b1;
                data_in = vec ? B'(xv[i]) : B'(mm[i / K][i % K]);
                i++;
            end
            @(negedge clk);
            if (i < total && busy !== 1'b1) busy_ok = 1'b0;
        end
        data_valid = 1'b0;
        chk(vec ? "vload_busy_held" : "mload_busy_held", busy_ok, 1);
        chk(vec ? "vload_idle_after" : "mload_idle_after", busy, 0);
    endtask

    // rmode: 0 always ready, 1 ready low 5 cycles after y[3], 2 random ready
    task automatic run(input int rmode, input bit poke);
        int n = 0;
        int got = 0;
        int cyc = 0;
        int stall = 0;
        bit rdy;
        model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_compute", busy, 1);
        while (done !== 1'b1 && n < LAT + 50) begin
            start = (poke && n == 10);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_latency", n, LAT);
        chk("out_valid_at_done", out_valid, 1);
        while (got < K && cyc < 20 * K) begin
            if (cyc == 1) chk("done_pulse_width", done, 0);
            case (rmode)
                0: rdy = 1'b1;
                1: begin rdy = (stall == 0); if (stall > 0) stall--; end
                default: rdy = ($urandom_range(1) == 1);
            endcase
            out_ready = rdy;
            if (out_valid) begin
                chk("data_out", data_out, yexp[got]);
                chk("out_last", out_last, (got == K - 1));
                if (rdy) begin
                    got++;
                    if (rmode == 1 && got == 4) stall = 5;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        chk("words_delivered", got, K);
        chk("out_valid_cleared", out_valid, 0);
        chk("busy_cleared", busy, 0);
        chk("overflow", overflow, oexp);
    endtask

    task automatic rand_fill(input bit do_m, input bit do_x);
        for (int i = 0; i < K; i++) begin
            if (do_x) xv[i] = int'($urandom_range(255)) - 128;
            if (do_m) for (int c = 0; c < K; c++) mm[i][c] = int'($urandom_range(255)) - 128;
        end
    endtask

    initial begin
        reset = 1'b0; load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0;
        data_in = '0; data_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_data_out", data_out, 0);
        reset = 1'b1;

        // identity matrix, x = 1..K
        for (int i = 0; i < K; i++) begin
            xv[i] = i + 1;
            for (int c = 0; c < K; c++) mm[i][c] = (i == c) ? 1 : 0;
        end
        load(1'b0, 0, 1'b0);
        load(1'b1, 0, 1'b0);
        run(0, 1'b0);

        // positive saturation
        for (int i = 0; i < K; i++) begin
            xv[i] = 127;
            for (int c = 0; c < K; c++) mm[i][c] = 127;
        end
        load(1'b0, 0, 1'b0);
        load(1'b1, 0, 1'b0);
        run(2, 1'b0);

        // negative saturation
        for (int i = 0; i < K; i++)
            for (int c = 0; c < K; c++) mm[i][c] = -128;
        load(1'b0, 0, 1'b0);
        run(0, 1'b0);

        // random data, dense load with output stall, then same data with gapped loads
        rand_fill(1'b1, 1'b1);
        load(1'b0, 0, 1'b0);
        load(1'b1, 0, 1'b0);
        run(1, 1'b0);
        load(1'b0, 1, 1'b0);
        load(1'b1, 1, 1'b0);
        run(0, 1'b0);

        // vector-only reload issued together with start; start poked during compute
        for (int i = 0; i < K; i++) xv[i] = 2;
        load(1'b1, 0, 1'b1);
        run(0, 1'b1);

        // reset in the middle of a compute
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // full reload with random gaps and random backpressure
        rand_fill(1'b1, 1'b1);
        load(1'b0, 2, 1'b0);
        load(1'b1, 2, 1'b0);
        run(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
